// File: rtl/add_sub_top.sv
// add_sub_top: 6-bit signed adder/subtractor demo block.
// Operands are captured from switches while the load button is held; the
// result and its overflow flag are registered one cycle later. Six active-low
// seven-segment digits show the decimal magnitudes of A, B and the result,
// with sign LEDs and an overflow LED.
// Optional feature: define ADD_SUB_BLANK_ZERO_EN to blank tens digits that are 0.

module add_sub_top (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] A,
    input  logic [5:0] B,
    input  logic       Add_Sub,
    input  logic       button,
    output logic [6:0] hex_A1,
    output logic [6:0] hex_A2,
    output logic [6:0] hex_B1,
    output logic [6:0] hex_B2,
    output logic [6:0] hex_Answer1,
    output logic [6:0] hex_Answer2,
    output logic       OF_LED,
    output logic       A_LED,
    output logic       B_LED,
    output logic       answer_LED
);

    // Two's-complement magnitude; -32 maps to 32, which still fits in 6 bits unsigned.
    function automatic logic [5:0] magnitude(input logic [5:0] v);
        logic [5:0] m;
        if (v[5]) begin
            m = (~v) + 6'd1;
        end else begin
            m = v;
        end
        return m;
    endfunction

    // Tens digit of a magnitude in the range 0..32.
    function automatic logic [1:0] tens_of(input logic [5:0] m);
        logic [1:0] t;
        if (m >= 6'd30) begin
            t = 2'd3;
        end else if (m >= 6'd20) begin
            t = 2'd2;
        end else if (m >= 6'd10) begin
            t = 2'd1;
        end else begin
            t = 2'd0;
        end
        return t;
    endfunction

    // Ones digit: subtract the tens contribution found by tens_of.
    function automatic logic [3:0] ones_of(input logic [5:0] m, input logic [1:0] t);
        logic [3:0] o;
        case (t)
            2'd0:    o = 4'(m);
            2'd1:    o = 4'(m - 6'd10);
            2'd2:    o = 4'(m - 6'd20);
            2'd3:    o = 4'(m - 6'd30);
            default: o = 4'hF;
        endcase
        return o;
    endfunction

    // Active-low segment pattern, bit order {g,f,e,d,c,b,a}; non-decimal codes blank.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Tens-digit pattern, optionally blanking a leading zero.
    function automatic logic [6:0] tens_seg(input logic [1:0] t);
        logic [6:0] s;
`ifdef ADD_SUB_BLANK_ZERO_EN
        if (t == 2'd0) begin
            s = 7'b1111111;
        end else begin
            s = seg7({2'b00, t});
        end
`else
        s = seg7({2'b00, t});
`endif
        return s;
    endfunction

    logic [5:0] a_r;
    logic [5:0] b_r;
    logic       op_r;
    logic [5:0] res_r;
    logic       of_r;

    logic [5:0] b_eff_s;
    logic [5:0] sum_s;
    logic       of_s;

    // Operand register: load while button is held, otherwise hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_r  <= 6'd0;
            b_r  <= 6'd0;
            op_r <= 1'b0;
        end else if (button) begin
            a_r  <= A;
            b_r  <= B;
            op_r <= Add_Sub;
        end else begin
            a_r  <= a_r;
            b_r  <= b_r;
            op_r <= op_r;
        end
    end

    // Add or subtract (A + ~B + 1) and detect signed overflow.
    always_comb begin
        b_eff_s = 6'd0;
        sum_s   = 6'd0;
        of_s    = 1'b0;
        if (op_r) begin
            b_eff_s = ~b_r;
        end else begin
            b_eff_s = b_r;
        end
        sum_s = a_r + b_eff_s + {5'd0, op_r};
        of_s  = (a_r[5] == b_eff_s[5]) && (sum_s[5] != a_r[5]);
    end

    // Result register: recomputed from the operand registers every cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_r <= 6'd0;
            of_r  <= 1'b0;
        end else begin
            res_r <= sum_s;
            of_r  <= of_s;
        end
    end

    logic [5:0] mag_a_s;
    logic [5:0] mag_b_s;
    logic [5:0] mag_r_s;
    logic [1:0] ten_a_s;
    logic [1:0] ten_b_s;
    logic [1:0] ten_r_s;

    // Display decode straight from the registers so digits track with minimal latency.
    always_comb begin
        mag_a_s     = magnitude(a_r);
        mag_b_s     = magnitude(b_r);
        mag_r_s     = magnitude(res_r);
        ten_a_s     = tens_of(mag_a_s);
        ten_b_s     = tens_of(mag_b_s);
        ten_r_s     = tens_of(mag_r_s);
        hex_A1      = seg7(ones_of(mag_a_s, ten_a_s));
        hex_A2      = tens_seg(ten_a_s);
        hex_B1      = seg7(ones_of(mag_b_s, ten_b_s));
        hex_B2      = tens_seg(ten_b_s);
        hex_Answer1 = seg7(ones_of(mag_r_s, ten_r_s));
        hex_Answer2 = tens_seg(ten_r_s);
        A_LED       = a_r[5];
        B_LED       = b_r[5];
        answer_LED  = res_r[5];
        OF_LED      = of_r;
    end

endmodule

// File: tb/tb_add_sub_top.sv
// Directed bench for add_sub_top: reset, add, subtract, hold, overflow cases.
module tb_add_sub_top;

    logic       clk;
    logic       rst_n;
    logic [5:0] A;
    logic [5:0] B;
    logic       Add_Sub;
    logic       button;
    logic [6:0] hex_A1, hex_A2, hex_B1, hex_B2, hex_Answer1, hex_Answer2;
    logic       OF_LED, A_LED, B_LED, answer_LED;

    int vectors;
    int miscompares;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000;
`ifdef ADD_SUB_BLANK_ZERO_EN
    localparam logic [6:0] T0 = 7'b1111111;
`else
    localparam logic [6:0] T0 = 7'b1000000;
`endif

    add_sub_top dut (
        .clk(clk), .rst_n(rst_n), .A(A), .B(B), .Add_Sub(Add_Sub), .button(button),
        .hex_A1(hex_A1), .hex_A2(hex_A2), .hex_B1(hex_B1), .hex_B2(hex_B2),
        .hex_Answer1(hex_Answer1), .hex_Answer2(hex_Answer2),
        .OF_LED(OF_LED), .A_LED(A_LED), .B_LED(B_LED), .answer_LED(answer_LED)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag,
                           input logic [6:0] ea2, input logic [6:0] ea1,
                           input logic [6:0] eb2, input logic [6:0] eb1,
                           input logic [6:0] er2, input logic [6:0] er1,
                           input logic eof, input logic eal, input logic ebl, input logic erl);
        chk({tag, ".hex_A2"}, hex_A2, ea2);
        chk({tag, ".hex_A1"}, hex_A1, ea1);
        chk({tag, ".hex_B2"}, hex_B2, eb2);
        chk({tag, ".hex_B1"}, hex_B1, eb1);
        chk({tag, ".hex_Answer2"}, hex_Answer2, er2);
        chk({tag, ".hex_Answer1"}, hex_Answer1, er1);
        chk({tag, ".OF_LED"}, {6'd0, OF_LED}, {6'd0, eof});
        chk({tag, ".A_LED"}, {6'd0, A_LED}, {6'd0, eal});
        chk({tag, ".B_LED"}, {6'd0, B_LED}, {6'd0, ebl});
        chk({tag, ".answer_LED"}, {6'd0, answer_LED}, {6'd0, erl});
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n   = 1'b0;
        button  = 1'b0;
        A       = 6'd0;
        B       = 6'd0;
        Add_Sub = 1'b0;

        // Reset for two edges, then release with button low.
        step(2);
        chk_all("reset", T0, S0, T0, S0, T0, S0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step(1);
        chk_all("post_reset", T0, S0, T0, S0, T0, S0, 1'b0, 1'b0, 1'b0, 1'b0);

        // 15 + 8 = 23: operands visible after 1 edge, answer after 2.
        A = 6'd15; B = 6'd8; Add_Sub = 1'b0; button = 1'b1;
        step(1);
        chk("add_lat1.hex_A2", hex_A2, S1);
        chk("add_lat1.hex_A1", hex_A1, S5);
        chk("add_lat1.hex_B1", hex_B1, S8);
        chk("add_lat1.hex_Answer1", hex_Answer1, S0);
        step(1);
        chk_all("add", S1, S5, T0, S8, S2, S3, 1'b0, 1'b0, 1'b0, 1'b0);

        // 1 - 9 = -8.
        A = 6'd1; B = 6'd9; Add_Sub = 1'b1;
        step(2);
        chk_all("sub_neg", T0, S1, T0, S9, T0, S8, 1'b0, 1'b0, 1'b0, 1'b1);

        // 14 - 10 = 4, then release button and wiggle inputs.
        A = 6'd14; B = 6'd10; Add_Sub = 1'b1;
        step(2);
        chk_all("hold_load", S1, S4, S1, S0, T0, S4, 1'b0, 1'b0, 1'b0, 1'b0);
        button = 1'b0; A = 6'd32; B = 6'd32; Add_Sub = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk_all("hold", S1, S4, S1, S0, T0, S4, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // 31 + 1 wraps to -32, overflow.
        A = 6'd31; B = 6'd1; Add_Sub = 1'b0; button = 1'b1;
        step(2);
        chk_all("ovf_add_pos", S3, S1, T0, S1, S3, S2, 1'b1, 1'b0, 1'b0, 1'b1);

        // -32 + -32 wraps to 0, overflow.
        A = 6'd32; B = 6'd32; Add_Sub = 1'b0;
        step(2);
        chk_all("ovf_add_neg", S3, S2, S3, S2, T0, S0, 1'b1, 1'b1, 1'b1, 1'b0);

        // -32 - 1 wraps to 31, overflow.
        A = 6'd32; B = 6'd1; Add_Sub = 1'b1;
        step(2);
        chk_all("ovf_sub", S3, S2, T0, S1, S3, S1, 1'b1, 1'b1, 1'b0, 1'b0);

        // 3 + 4 = 7: single-digit values exercise the tens-digit blanking.
        A = 6'd3; B = 6'd4; Add_Sub = 1'b0;
        step(2);
        chk_all("small", T0, S3, T0, S4, T0, S7, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset while button is held wins over loading.
        A = 6'd21; B = 6'd35; Add_Sub = 1'b1; rst_n = 1'b0;
        step(1);
        chk_all("reset_prio", T0, S0, T0, S0, T0, S0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // 21 - (-29) = 50 wraps to -14, overflow.
        step(2);
        chk_all("ovf_sub_pos", S2, S1, S2, S9, S1, S4, 1'b1, 1'b0, 1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/add_sub_top.md
# add_sub_top

Top-level 6-bit signed adder/subtractor for a board-level demo. Operands come from slide switches and are captured while a load button is held. The block registers the operands and the result. It drives six active-low seven-segment digits showing the decimal magnitudes of A, B and the answer, with sign LEDs for each and an overflow LED.

## Interface
- No parameters; widths are fixed.
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  reset, synchronous, active-low
- A  in  6  operand A, two's complement (-32..31)
- B  in  6  operand B, two's complement
- Add_Sub  in  1  0 = A+B, 1 = A-B
- button  in  1  load enable, active-high, level-sensitive
- hex_A1 / hex_A2  out  7  A magnitude ones / tens digit
- hex_B1 / hex_B2  out  7  B magnitude ones / tens digit
- hex_Answer1 / hex_Answer2  out  7  result magnitude ones / tens digit
- OF_LED  out  1  signed overflow of last result
- A_LED / B_LED / answer_LED  out  1  sign (1 = negative) of A / B / result

## Operation
- Operand stage:
  - On a clock edge with rst_n=1 and button=1, load A_r<=A, B_r<=B, op_r<=Add_Sub.
  - With button=0, hold all three registers.
- Result stage, every edge with rst_n=1:
  - res_r <= A_r + B_r when op_r=0.
  - res_r <= A_r + ~B_r + 1 when op_r=1.
  - The sum is truncated to 6 bits.
- OF_r: set when the operand signs (B inverted for subtract) match and the result sign differs.
  - Addition overflow example: 31+1 gives 6'b100000, OF=1.
  - Subtraction overflow example: -32-1 gives 31, OF=1.
- Overflowed result still displays its wrapped 6-bit value.
- Sign LEDs are bit 5 of A_r, B_r and res_r.
- Display path, combinational from registers:
  - Magnitude = value if bit5=0, else the two's-complement negation (-32 gives 32).
  - Tens digit = magnitude/10 (0..3); ones digit = magnitude%10.
- Segment encoding is active-low, bit order {g,f,e,d,c,b,a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Any other code shows 1111111 (blank).
- Out-of-range inputs (e.g. 6'd64 driven from a wider source) are truncated by port width; 64 becomes 0.

## Timing
- Reset (rst_n=0 at an edge) clears A_r, B_r, op_r, res_r, OF_r to 0.
  - All hex outputs read 1000000 ("0", or blank tens per Configuration).
  - All LEDs read 0.
- Reset mid-operation takes priority over button.
- A and B displays and their sign LEDs update 1 cycle after the sampling edge.
- Answer digits, answer_LED and OF_LED update 2 cycles after the sampling edge.
- With button held high, inputs stream through with that latency every cycle.
- Releasing button freezes operands; the result settles on the next edge and then holds indefinitely.
- Changing Add_Sub with button=0 has no effect.

## Configuration
- ADD_SUB_BLANK_ZERO_EN defined: every tens digit (hex_A2, hex_B2, hex_Answer2) whose value is 0 outputs 1111111 (blank). This includes reset.
- ADD_SUB_BLANK_ZERO_EN undefined: tens digits always show their digit, including "0" as 1000000.

## Test plan
- Reset:
  - Stimulus: rst_n=0 for 2 edges, then release with button=0.
  - Required: all hex outputs = 1000000 (macro off); all four LEDs = 0.
- Add:
  - Stimulus: A=15, B=8, Add_Sub=0, button=1.
  - Required after 2 edges: hex_Answer2=0100100 ("2"), hex_Answer1=0110000 ("3"); OF_LED=0, answer_LED=0.
  - Required: hex_A2/hex_A1 show "15", hex_B1 shows "8".
- Subtract to negative:
  - Stimulus: A=1, B=9, Add_Sub=1, button=1.
  - Required: result -8; answer_LED=1, hex_Answer1 = "8", hex_Answer2 = "0"; OF_LED=0.
- Hold:
  - Stimulus: after A=14, B=10, Add_Sub=1 is loaded ("4" shown), drop button and drive A=6'd32, B=6'd32, Add_Sub=0.
  - Required: all outputs unchanged for ≥4 cycles.
- Overflow:
  - Stimulus: A=31, B=1, Add, button=1.
  - Required: OF_LED=1, answer_LED=1, answer shows "32".
  - Stimulus: A=6'd32 (-32), B=6'd32, Add.
  - Required: result 0, OF_LED=1, A_LED=B_LED=1, A and B digits show "32".
- Macro on:
  - Stimulus: A=3, B=4, Add.
  - Required: hex_A2, hex_B2, hex_Answer2 = 1111111; hex_Answer1 = 1111000 ("7").
